// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and its word store.
package prog_loader_pkg;

   localparam int              WORD_W    = 12;
   localparam int              ADDR_W    = 8;
   localparam logic [WORD_W-1:0] STOP_WORD = 12'h300;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      LO,
      HI,
      CHK,
      RUN,
      ERR
   } state_e;

endpackage

// File: rtl/prog_ram.sv
// Program word store: one synchronous write port, one asynchronous read port.
module prog_ram
   import prog_loader_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   // No reset: unloaded words are masked downstream by the committed count.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: header, word pairs, XOR checksum, then releases
// the processor from reset and serves instruction fetches from the store.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   HDR   | expecting header byte N (0 = 256 words)
//   LO    | expecting low byte of next word
//   HI    | expecting high byte (upper nibble must be zero), writes word
//   CHK   | expecting checksum byte
//   RUN   | load committed, processor out of reset
//   ERR   | last load failed, processor held in reset
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int                DEPTH     = 256,
   parameter logic [WORD_W-1:0] STOP_WORD = prog_loader_pkg::STOP_WORD
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] progaddr,
   output logic [WORD_W-1:0] prog,
   output logic              core_reset,
   output logic [ADDR_W-1:0] loaded,
   output logic              full_flag,
   output logic              err
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [7:0]        count_q, count_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        cs_q, cs_d;
   logic [ADDR_W-1:0] loaded_q, loaded_d;
   logic              full_q, full_d;
   logic              err_q, err_d;
   logic              xfer;
   logic              we;
   logic [WORD_W-1:0] rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         wptr_q   <= '0;
         count_q  <= '0;
         lo_q     <= '0;
         cs_q     <= '0;
         loaded_q <= '0;
         full_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         count_q  <= count_d;
         lo_q     <= lo_d;
         cs_q     <= cs_d;
         loaded_q <= loaded_d;
         full_q   <= full_d;
         err_q    <= err_d;
      end
   end

   assign byte_ready = (state_q == HDR) || (state_q == LO) ||
                       (state_q == HI)  || (state_q == CHK);
   assign xfer       = byte_valid && byte_ready;

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      count_d  = count_q;
      lo_d     = lo_q;
      cs_d     = cs_q;
      loaded_d = loaded_q;
      full_d   = full_q;
      err_d    = err_q;
      we       = 1'b0;
      // start outranks any byte offered in the same cycle
      if (start) begin
         state_d  = HDR;
         wptr_d   = '0;
         cs_d     = '0;
         loaded_d = '0;
         full_d   = 1'b0;
         err_d    = 1'b0;
      end else if (xfer) begin
         case (state_q)
            HDR: begin
               count_d = byte_in;
               cs_d    = byte_in;
               state_d = LO;
            end
            LO: begin
               lo_d    = byte_in;
               cs_d    = cs_q ^ byte_in;
               state_d = HI;
            end
            HI: begin
               if (byte_in[7:4] != 4'h0) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else begin
                  we      = 1'b1;
                  wptr_d  = wptr_q + 8'd1;
                  cs_d    = cs_q ^ byte_in;
                  // count of 0 means 256, so the last word lands at wptr 255
                  state_d = (wptr_q == count_q - 8'd1) ? CHK : LO;
               end
            end
            CHK: begin
               if (byte_in == cs_q) begin
                  loaded_d = count_q;
                  full_d   = (count_q == 8'd0);
                  state_d  = RUN;
               end else begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   prog_ram #(.DEPTH(DEPTH)) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wptr_q),
      .wdata_i ({byte_in[3:0], lo_q}),
      .raddr_i (progaddr),
      .rdata_o (rdata)
   );

   assign prog       = (full_q || (progaddr < loaded_q)) ? rdata : STOP_WORD;
   assign core_reset = (state_q != RUN);
   assign loaded     = loaded_q;
   assign full_flag  = full_q;
   assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized checks of prog_loader against a word-array model.
module tb_prog_loader;
   import prog_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        byte_valid = 1'b0;
   logic        byte_ready;
   logic [7:0]  progaddr = '0;
   logic [11:0] prog;
   logic        core_reset;
   logic [7:0]  loaded;
   logic        full_flag;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [11:0] ref_mem [256];
   int          ref_loaded = 0;
   logic [11:0] stim_w [256];

   prog_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .progaddr   (progaddr),
      .prog       (prog),
      .core_reset (core_reset),
      .loaded     (loaded),
      .full_flag  (full_flag),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] ref_prog(input int a);
      return (a < ref_loaded) ? ref_mem[a] : 12'h300;
   endfunction

   task automatic check_all_addrs(input string tag);
      for (int a = 0; a < 256; a++) begin
         progaddr = a[7:0];
         #1;
         check(tag, {20'd0, prog}, {20'd0, ref_prog(a)});
      end
      tick();
   endtask

   task automatic check_status();
      check("loaded", {24'd0, loaded}, ref_loaded & 32'hFF);
      check("full_flag", {31'd0, full_flag}, {31'd0, ref_loaded == 256});
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int t = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            byte_valid = 1'b0;
            tick();
         end
      end
      while (!byte_ready && t < 20) begin
         tick();
         t++;
      end
      check("byte_ready", {31'd0, byte_ready}, 32'd1);
      byte_valid = 1'b1;
      byte_in    = b;
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      ref_loaded = 0;
   endtask

   // Sends header, n words from stim_w and the checksum; n in 1..256.
   task automatic send_stream(input int n, input bit bad, input bit gaps);
      logic [7:0] cs, lo, hi, h;
      h  = n[7:0];
      cs = h;
      send_byte(h, gaps);
      for (int i = 0; i < n; i++) begin
         lo = stim_w[i][7:0];
         hi = {4'h0, stim_w[i][11:8]};
         cs = cs ^ lo ^ hi;
         send_byte(lo, gaps);
         send_byte(hi, gaps);
         ref_mem[i] = stim_w[i];
      end
      if (bad) cs = cs ^ 8'h01;
      check("core_reset_before_cs", {31'd0, core_reset}, 32'd1);
      send_byte(cs, gaps);
      ref_loaded = bad ? 0 : n;
      check("core_reset_after_cs", {31'd0, core_reset}, bad ? 32'd1 : 32'd0);
   endtask

   task automatic do_load(input int n, input bit bad, input bit gaps);
      pulse_start();
      send_stream(n, bad, gaps);
   endtask

   initial begin
      int n;
      // reset state
      repeat (3) tick();
      check("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
      check_status();
      reset_n = 1'b1;
      tick();
      progaddr = 8'd0;
      #1;
      check("rst_prog0", {20'd0, prog}, 32'h300);

      // byte_valid ignored in IDLE
      byte_valid = 1'b1; byte_in = 8'h03;
      repeat (3) tick();
      byte_valid = 1'b0;
      check("idle_ignore", {29'd0, dut.state_q}, {29'd0, IDLE});

      // 3-word directed load
      stim_w[0] = 12'h884; stim_w[1] = 12'h895; stim_w[2] = 12'h9A0;
      do_load(3, 1'b0, 1'b0);
      check_status();
      check("load3_err", {31'd0, err}, 32'd0);
      check_all_addrs("load3_prog");
      progaddr = 8'd5; #1;
      check("load3_prog5", {20'd0, prog}, 32'h300);

      // byte_valid ignored in RUN
      byte_valid = 1'b1; byte_in = 8'h55;
      repeat (4) tick();
      byte_valid = 1'b0;
      check("run_ignore", {31'd0, core_reset}, 32'd0);
      check_status();

      // bad checksum
      do_load(3, 1'b1, 1'b0);
      check("badcs_err", {31'd0, err}, 32'd1);
      check("badcs_state", {29'd0, dut.state_q}, {29'd0, ERR});
      check("badcs_ready", {31'd0, byte_ready}, 32'd0);
      check_status();
      progaddr = 8'd0; #1;
      check("badcs_prog0", {20'd0, prog}, 32'h300);

      // high-nibble error: no write of 0x300 into word 0
      pulse_start();
      check("start_clears_err", {31'd0, err}, 32'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hF3, 1'b0);
      check("hinib_err", {31'd0, err}, 32'd1);
      check("hinib_ready", {31'd0, byte_ready}, 32'd0);
      check("hinib_core_reset", {31'd0, core_reset}, 32'd1);
      check("hinib_nowrite", {20'd0, dut.u_ram.mem_q[0]}, {20'd0, ref_mem[0]});

      // random partial loads with backpressure
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) stim_w[i] = 12'($urandom);
         do_load(n, 1'b0, 1'b1);
         check_status();
         check_all_addrs("rand_prog");
      end

      // full 256-word load
      for (int i = 0; i < 256; i++) stim_w[i] = 12'($urandom);
      do_load(256, 1'b0, 1'b0);
      check_status();
      check("full_wptr_wrap", {24'd0, dut.wptr_q}, 32'd0);
      progaddr = 8'd255; #1;
      check("full_prog255", {20'd0, prog}, {20'd0, stim_w[255]});
      check_all_addrs("full_prog");

      // backpressure then restart after 2 words
      pulse_start();
      send_byte(8'h05, 1'b1);
      for (int i = 0; i < 2; i++) begin
         stim_w[i] = 12'($urandom);
         send_byte(stim_w[i][7:0], 1'b1);
         send_byte({4'h0, stim_w[i][11:8]}, 1'b1);
         ref_mem[i] = stim_w[i];
      end
      pulse_start();
      check("restart_state", {29'd0, dut.state_q}, {29'd0, HDR});
      check("restart_ready", {31'd0, byte_ready}, 32'd1);
      check_status();
      stim_w[0] = 12'($urandom);
      send_stream(1, 1'b0, 1'b1);
      check_status();
      check_all_addrs("restart_prog");

      // reset during HI
      pulse_start();
      send_byte(8'h04, 1'b0);
      send_byte(8'h12, 1'b0);
      check("midload_in_hi", {29'd0, dut.state_q}, {29'd0, HI});
      #3;
      reset_n = 1'b0;
      ref_loaded = 0;
      #1;
      check("midrst_state", {29'd0, dut.state_q}, {29'd0, IDLE});
      check("midrst_core_reset", {31'd0, core_reset}, 32'd1);
      check("midrst_ready", {31'd0, byte_ready}, 32'd0);
      check_status();
      check_all_addrs("midrst_prog");
      reset_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 12-bit program words; the address width is 8 bits.
REQ-002 SHALL have parameter STOP_WORD, default 12'h300, meaning the word returned for unloaded addresses (the stop opcode).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle pulse that begins a load.
REQ-006 SHALL have port byte_in, input, 8, meaning the loader data byte.
REQ-007 SHALL have port byte_valid, input, 1, meaning byte_in is valid.
REQ-008 SHALL have port byte_ready, output, 1, meaning the loader can accept a byte.
REQ-009 SHALL have port progaddr, input, 8, meaning the processor fetch address.
REQ-010 SHALL have port prog, output, 12, meaning the instruction word at progaddr.
REQ-011 SHALL have port core_reset, output, 1, meaning active-high reset driven to the processor.
REQ-012 SHALL have port loaded, output, 8, meaning the committed word count (low 8 bits; 0 means none loaded, or 256 when full_flag=1).
REQ-013 SHALL have port full_flag, output, 1, meaning all 256 words are committed.
REQ-014 SHALL have port err, output, 1, meaning the last load failed.

Function
REQ-015 SHALL implement states IDLE, HDR, LO, HI, CHK, RUN and ERR.
REQ-016 SHALL transfer a byte only in a cycle where byte_valid=1 and byte_ready=1.
REQ-017 SHALL drive byte_ready=1 only in HDR, LO, HI and CHK.
REQ-018 SHALL interpret the stream as: header byte N (N=0 means 256 words), then N pairs (low byte = prog[7:0], high byte with bits[3:0] = prog[11:8]), then one checksum byte.
REQ-019 SHALL define the checksum as the XOR of the header byte and all pair bytes.
REQ-020 SHALL move from IDLE, RUN or ERR to HDR on start=1.
REQ-021 SHALL, on start=1 in HDR, LO, HI or CHK, restart at HDR and discard the partial load.
REQ-022 SHALL set loaded=0, full_flag=0 and err=0 on every start.
REQ-023 SHALL make transitions HDR to LO, LO to HI, and HI to LO, or HI to CHK after the Nth word, each on one accepted byte.
REQ-024 SHALL go to ERR from HI, without writing the word, when the high byte has bits[7:4] not equal to 0.
REQ-025 SHALL, on each accepted HI byte, write RAM[wptr] with {hi[3:0], lo} and then increment wptr (8-bit, starting at 0).
REQ-026 SHALL, on a checksum match in CHK, commit loaded=N (with full_flag=1 when N=0) and go to RUN on the next edge.
REQ-027 SHALL, on a checksum mismatch in CHK, go to ERR and set err=1.
REQ-028 SHALL assert core_reset=1 in every state except RUN.
REQ-029 SHALL deassert core_reset in the cycle after the commit.
REQ-030 SHALL drive prog combinationally as RAM[progaddr] when full_flag=1 or progaddr < loaded, and as STOP_WORD otherwise.
REQ-031 SHALL add no latency between progaddr and prog, so the processor fetches within the same cycle.
REQ-032 SHALL ignore byte_valid in IDLE, RUN and ERR.

Reset
REQ-033 SHALL, when reset_n=0 (asynchronous), set state=IDLE, wptr=0, loaded=0, full_flag=0, err=0, core_reset=1 and byte_ready=0.
REQ-034 SHALL leave RAM contents unchanged by reset; they are masked to STOP_WORD by loaded=0.
REQ-035 SHALL, when reset_n asserts mid-load, abandon the load with no commit.

Structure
REQ-036 SHALL place the state enum, STOP_WORD, the word width (12) and the address width (8) in the shared package prog_loader_pkg.
REQ-037 SHALL instantiate one sub-module, prog_ram: 256x12 storage with one synchronous write port and one asynchronous read port.

Verification
REQ-038 SHALL verify a 3-word load: start, bytes 03,84,08,95,08,A0,09,cs=XOR -> RAM[0..2]=884,895,9A0; loaded=3; core_reset falls 1 cycle after checksum; prog@addr5=300.
REQ-039 SHALL verify a bad checksum: same stream with cs^01 -> err=1, state ERR, core_reset=1, loaded=0, prog@addr0=300.
REQ-040 SHALL verify the high-nibble error: header 01, then 00, F3 -> ERR immediately, no RAM write, byte_ready=0.
REQ-041 SHALL verify a full load: header 00, then 256 pairs, then valid cs -> loaded=0, full_flag=1, RAM[255] readable, wptr wraps to 0.
REQ-042 SHALL verify backpressure and restart: byte_valid toggled randomly, then start pulsed after 2 words -> returns to HDR, loaded=0, and a new load of 1 word commits correctly.
REQ-043 SHALL verify reset mid-load: reset_n low during HI -> IDLE, core_reset=1, prog=300 for all addresses.
